down_counter_timer: RTL and testbench

//  Loadable, prescaled down-counter: the countdown counterpart of the 3-bit up-counter.

---
 rtl/down_counter_timer_pkg.sv | 19 +
 rtl/tick_prescaler.sv | 35 +++
 rtl/down_counter_timer.sv | 112 +++++++++++
 tb/tb_down_counter_timer.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/down_counter_timer_pkg.sv
// Shared definitions for the down-counter timer: FSM state encodings,
// default sizing and the prescaler counter width helper.
package down_counter_timer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_HOLD = 2'd2
   } state_e;

   localparam int DEF_WIDTH = 3;
   localparam int DEF_PRESC = 1;

   // A prescale of 1 still needs a 1-bit counter so the port widths stay legal.
   function automatic int presc_w(input int presc);
      return ($clog2(presc) > 1) ? $clog2(presc) : 1;
   endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides the clock by PRESC while enabled, emitting a one-cycle tick
// on the last count; clr restarts the division from zero.
module tick_prescaler
   import down_counter_timer_pkg::*;
#(
   parameter int PRESC = DEF_PRESC
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic tick
);

   localparam int            PW   = presc_w(PRESC);
   localparam logic [PW-1:0] LAST = PW'(PRESC - 1);

   logic [PW-1:0] cnt_q, cnt_d;

   assign tick = en && (cnt_q == LAST);

   always_comb begin
      cnt_d = cnt_q;
      if (clr)
         cnt_d = '0;
      else if (en)
         cnt_d = tick ? '0 : cnt_q + PW'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

endmodule

// File: rtl/down_counter_timer.sv
// Loadable prescaled down-counter: counts load_val down to zero, pulses done
// on expiry and optionally reloads for periodic operation.
module down_counter_timer
   import down_counter_timer_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int PRESC = DEF_PRESC
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] load_val,
   input  logic             auto_reload,
   input  logic             hold,
   input  logic             abort,
   output logic [WIDTH-1:0] count,
   output logic             busy,
   output logic             done
);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic [WIDTH-1:0] reload_q, reload_d;
   logic             ar_q, ar_d;
   logic             done_q, done_d;
   logic             start_ok, presc_en, tick;

   // The prescaler only advances on edges where RUN actually counts; abort and
   // hold take priority, and a start outside IDLE must not disturb it.
   assign start_ok = start && (state_q == ST_IDLE);
   assign presc_en = (state_q == ST_RUN) && !hold && !abort;

   tick_prescaler #(.PRESC(PRESC)) u_presc (
      .clk  (clk),
      .rst  (rst),
      .clr  (start_ok),
      .en   (presc_en),
      .tick (tick)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         count_q  <= '0;
         reload_q <= '0;
         ar_q     <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         reload_q <= reload_d;
         ar_q     <= ar_d;
         done_q   <= done_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      reload_d = reload_q;
      ar_d     = ar_q;
      done_d   = 1'b0;
      if (abort && state_q != ST_IDLE) begin
         count_d = '0;
         state_d = ST_IDLE;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (start) begin
                  if (load_val != '0) begin
                     count_d  = load_val;
                     reload_d = load_val;
                     ar_d     = auto_reload;
                     state_d  = ST_RUN;
                  end else begin
                     count_d = '0;
                     done_d  = 1'b1;
                  end
               end
            end
            ST_RUN: begin
               if (hold)
                  state_d = ST_HOLD;
               else if (tick) begin
                  // Expiry goes 1 -> 0 or 1 -> reload; zero is never decremented.
                  if (count_q > WIDTH'(1))
                     count_d = count_q - WIDTH'(1);
                  else if (ar_q) begin
                     count_d = reload_q;
                     done_d  = 1'b1;
                  end else begin
                     count_d = '0;
                     done_d  = 1'b1;
                     state_d = ST_IDLE;
                  end
               end
            end
            ST_HOLD: begin
               if (!hold) state_d = ST_RUN;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      count = count_q;
      done  = done_q;
      busy  = (state_q == ST_RUN) || (state_q == ST_HOLD);
   end

endmodule

// File: tb/tb_down_counter_timer.sv
// Directed bench: a vector table drives the PRESC=1 timer; hand sequences
// cover reset with random inputs and the PRESC=4 timing/reset corners.
module tb_down_counter_timer;

   localparam int W = 3;

   logic         clk = 1'b0;
   logic         rst, start, auto_reload, hold, abort;
   logic [W-1:0] load_val;
   logic [W-1:0] count1, count4;
   logic         busy1, busy4, done1, done4;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   down_counter_timer #(.WIDTH(W), .PRESC(1)) dut1 (
      .clk(clk), .rst(rst), .start(start), .load_val(load_val),
      .auto_reload(auto_reload), .hold(hold), .abort(abort),
      .count(count1), .busy(busy1), .done(done1)
   );

   down_counter_timer #(.WIDTH(W), .PRESC(4)) dut4 (
      .clk(clk), .rst(rst), .start(start), .load_val(load_val),
      .auto_reload(auto_reload), .hold(hold), .abort(abort),
      .count(count4), .busy(busy4), .done(done4)
   );

   typedef struct {
      logic         rst, start, ar, hold, abort;
      logic [W-1:0] load;
      logic [W-1:0] ec;
      logic         eb, ed;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input logic r, input logic s, input int ld, input logic a,
                               input logic h, input logic ab, input int ec,
                               input logic eb, input logic ed);
      vec_t v;
      v.rst = r; v.start = s; v.load = W'(ld); v.ar = a; v.hold = h; v.abort = ab;
      v.ec = W'(ec); v.eb = eb; v.ed = ed;
      return v;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic drive(input logic r, input logic s, input int ld, input logic a,
                        input logic h, input logic ab);
      rst = r; start = s; load_val = W'(ld); auto_reload = a; hold = h; abort = ab;
      @(posedge clk);
      #1;
   endtask

   task automatic chk4(input string tag, input int ec, input logic eb, input logic ed);
      chk({tag, " count"}, int'(count4), ec);
      chk({tag, " busy"},  int'(busy4),  int'(eb));
      chk({tag, " done"},  int'(done4),  int'(ed));
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; load_val = '0; auto_reload = 1'b0; hold = 1'b0; abort = 1'b0;

      // Reset held for 3 clocks with random other inputs.
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'($urandom_range(1)), int'($urandom_range(7)), 1'($urandom_range(1)),
               1'($urandom_range(1)), 1'($urandom_range(1)));
         chk($sformatf("rst%0d count1", i), int'(count1), 0);
         chk($sformatf("rst%0d busy1", i),  int'(busy1),  0);
         chk($sformatf("rst%0d done1", i),  int'(done1),  0);
         chk4($sformatf("rst%0d p4", i), 0, 1'b0, 1'b0);
      end

      //               rst  st  ld ar hold abort  count busy done
      tbl.push_back(mk(1'b1,1'b0,0,1'b0,1'b0,1'b0, 0,1'b0,1'b0));
      // one-shot load 5
      tbl.push_back(mk(1'b0,1'b1,5,1'b0,1'b0,1'b0, 5,1'b1,1'b0));
      tbl.push_back(mk(1'b0,1'b0,0,1'b0,1'b0,1'b0, 4,1'b1,1'b0));
      tbl.push_back(mk(1'b0,1'b0,0,1'b0,1'b0,1'b0, 3,1'b1,1'b0));
      tbl.push_back(mk(1'b0,1'b0,0,1'b0,1'b0,1'b0, 2,1'b1,1'b0));
      tbl.push_back(mk(1'b0,1'b0,0,1'b0,1'b0,1'b0, 1,1'b1,1'b0));
      tbl.push_back(mk(1'b0,1'b0,0,1'b0,1'b0,1'b0, 0,1'b0,1'b1));
      tbl.push_back(mk(1'b0,1'b0,0,1'b0,1'b0,1'b0, 0,1'b0,1'b0));
      // auto-reload load 3, then abort at count 2
      tbl.push_back(mk(1'b0,1'b1,3,1'b1,1'b0,1'b0, 3,1'b1,1'b0));
      tbl.push_back(mk(1'b0,1'b0,0,1'b0,1'b0,1'b0, 2,1'b1,1'b0));
      tbl.push_back(mk(1'b0,1'b0,0,1'b0,1'b0,1'b0, 1,1'b1,1'b0));
      tbl.push_back(mk(1'b0,1'b0,0,1'b0,1'b0,1'b0, 3,1'b1,1'b1));
      tbl.push_back(mk(1'b0,1'b0,0,1'b0,1'b0,1'b0, 2,1'b1,1'b0));
      tbl.push_back(mk(1'b0,1'b0,0,1'b0,1'b0,1'b0, 1,1'b1,1'b0));
      tbl.push_back(mk(1'b0,1'b0,0,1'b0,1'b0,1'b0, 3,1'b1,1'b1));
      tbl.push_back(mk(1'b0,1'b0,0,1'b0,1'b0,1'b0, 2,1'b1,1'b0));
      tbl.push_back(mk(1'b0,1'b0,0,1'b0,1'b0,1'b1, 0,1'b0,1'b0));
      tbl.push_back(mk(1'b0,1'b0,0,1'b0,1'b0,1'b0, 0,1'b0,1'b0));
      // load 7, hold 4 clocks at count 4, start ignored while running
      tbl.push_back(mk(1'b0,1'b1,7,1'b0,1'b0,1'b0, 7,1'b1,1'b0));
      tbl.push_back(mk(1'b0,1'b0,0,1'b0,1'b0,1'b0, 6,1'b1,1'b0));
      tbl.push_back(mk(1'b0,1'b0,0,1'b0,1'b0,1'b0, 5,1'b1,1'b0));
      tbl.push_back(mk(1'b0,1'b0,0,1'b0,1'b0,1'b0, 4,1'b1,1'b0));
      tbl.push_back(mk(1'b0,1'b0,0,1'b0,1'b1,1'b0, 4,1'b1,1'b0));
      tbl.push_back(mk(1'b0,1'b0,0,1'b0,1'b1,1'b0, 4,1'b1,1'b0));
      tbl.push_back(mk(1'b0,1'b0,0,1'b0,1'b1,1'b0, 4,1'b1,1'b0));
      tbl.push_back(mk(1'b0,1'b0,0,1'b0,1'b1,1'b0, 4,1'b1,1'b0));
      tbl.push_back(mk(1'b0,1'b0,0,1'b0,1'b0,1'b0, 4,1'b1,1'b0));
      tbl.push_back(mk(1'b0,1'b1,2,1'b0,1'b0,1'b0, 3,1'b1,1'b0));
      tbl.push_back(mk(1'b0,1'b0,0,1'b0,1'b0,1'b0, 2,1'b1,1'b0));
      tbl.push_back(mk(1'b0,1'b0,0,1'b0,1'b0,1'b0, 1,1'b1,1'b0));
      tbl.push_back(mk(1'b0,1'b0,0,1'b0,1'b0,1'b0, 0,1'b0,1'b1));
      // load 0: immediate done, never busy
      tbl.push_back(mk(1'b0,1'b1,0,1'b0,1'b0,1'b0, 0,1'b0,1'b1));
      tbl.push_back(mk(1'b0,1'b0,0,1'b0,1'b0,1'b0, 0,1'b0,1'b0));
      // abort and hold in IDLE do nothing
      tbl.push_back(mk(1'b0,1'b0,0,1'b0,1'b1,1'b1, 0,1'b0,1'b0));
      // abort while in HOLD
      tbl.push_back(mk(1'b0,1'b1,4,1'b0,1'b0,1'b0, 4,1'b1,1'b0));
      tbl.push_back(mk(1'b0,1'b0,0,1'b0,1'b1,1'b0, 4,1'b1,1'b0));
      tbl.push_back(mk(1'b0,1'b0,0,1'b0,1'b1,1'b1, 0,1'b0,1'b0));
      tbl.push_back(mk(1'b0,1'b0,0,1'b0,1'b0,1'b0, 0,1'b0,1'b0));

      foreach (tbl[i]) begin
         drive(tbl[i].rst, tbl[i].start, int'(tbl[i].load), tbl[i].ar, tbl[i].hold, tbl[i].abort);
         chk($sformatf("vec%0d count", i), int'(count1), int'(tbl[i].ec));
         chk($sformatf("vec%0d busy", i),  int'(busy1),  int'(tbl[i].eb));
         chk($sformatf("vec%0d done", i),  int'(done1),  int'(tbl[i].ed));
      end

      // PRESC=4, load 2: one decrement every 4 clocks, done 8 clocks after start.
      drive(1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0);
      chk4("p4 rst", 0, 1'b0, 1'b0);
      drive(1'b0, 1'b1, 2, 1'b0, 1'b0, 1'b0);
      chk4("p4 start", 2, 1'b1, 1'b0);
      for (int k = 1; k <= 8; k++) begin
         drive(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
         chk4($sformatf("p4 k%0d", k), (k < 4) ? 2 : (k < 8) ? 1 : 0, k < 8, k == 8);
      end
      drive(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
      chk4("p4 after", 0, 1'b0, 1'b0);

      // Same again, reset once count reaches 1: zeros next edge and no done.
      drive(1'b0, 1'b1, 2, 1'b0, 1'b0, 1'b0);
      chk4("p4b start", 2, 1'b1, 1'b0);
      for (int k = 1; k <= 4; k++) drive(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
      chk4("p4b at1", 1, 1'b1, 1'b0);
      drive(1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0);
      chk4("p4b rst", 0, 1'b0, 1'b0);
      for (int k = 1; k <= 5; k++) begin
         drive(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
         chk4($sformatf("p4b post%0d", k), 0, 1'b0, 1'b0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
